uart_text_window: RTL

- Upstream text source for ascii_to_7seg; an alternative to digit_scroll in the seven-segment demo top level.
- Receives 8N1 UART bytes on a single RX pin.
- Keeps the last four printable characters in a left-scrolling 4-character window and drives asciiOne..asciiFour directly.
- Lets a PC terminal write text to the Basys2 display.

---
 rtl/uart_text_window.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_text_window.sv
// 8N1 UART receiver feeding a left-scrolling 4-character text window for ascii_to_7seg.
// Window/rxData/pulses register one cycle after the stop sample (+2 cycles rx sync); no backpressure.
module uart_text_window #(
   parameter int          CYCLES_PER_BIT = 5208,
   parameter logic [7:0]  BLANK_CHAR     = 8'h20
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       rx,
   output logic [7:0] asciiOne,
   output logic [7:0] asciiTwo,
   output logic [7:0] asciiThree,
   output logic [7:0] asciiFour,
   output logic [7:0] rxData,
   output logic       rxValid,
   output logic       frameErr
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_IDLE = 3'd4;

   localparam logic [15:0] HALF_LAST = 16'(CYCLES_PER_BIT / 2 - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_BIT - 1);

   logic        rxMeta;
   logic        rxS;
   logic [2:0]  state;
   logic [15:0] bitCnt;
   logic [2:0]  bitIdx;
   logic [7:0]  shiftReg;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxS    <= rxMeta;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= IDLE;
         bitCnt     <= 16'd0;
         bitIdx     <= 3'd0;
         shiftReg   <= 8'h00;
         rxData     <= 8'h00;
         rxValid    <= 1'b0;
         frameErr   <= 1'b0;
         asciiOne   <= BLANK_CHAR;
         asciiTwo   <= BLANK_CHAR;
         asciiThree <= BLANK_CHAR;
         asciiFour  <= BLANK_CHAR;
      end else begin
         rxValid  <= 1'b0;
         frameErr <= 1'b0;
         case (state)
            IDLE: begin
               if (!rxS) begin
                  state  <= START;
                  bitCnt <= 16'd0;
               end
            end
            START: begin
               // Mid-start-bit recheck rejects short glitches on the idle line.
               if (bitCnt == HALF_LAST) begin
                  bitCnt <= 16'd0;
                  bitIdx <= 3'd0;
                  state  <= rxS ? IDLE : DATA;
               end else begin
                  bitCnt <= bitCnt + 16'd1;
               end
            end
            DATA: begin
               if (bitCnt == BIT_LAST) begin
                  bitCnt           <= 16'd0;
                  shiftReg[bitIdx] <= rxS;
                  bitIdx           <= bitIdx + 3'd1;
                  if (bitIdx == 3'd7) state <= STOP;
               end else begin
                  bitCnt <= bitCnt + 16'd1;
               end
            end
            STOP: begin
               if (bitCnt == BIT_LAST) begin
                  bitCnt <= 16'd0;
                  if (rxS) begin
                     state   <= IDLE;
                     rxValid <= 1'b1;
                     rxData  <= shiftReg;
                     if (shiftReg >= 8'h20 && shiftReg <= 8'h7E) begin
                        asciiOne   <= asciiTwo;
                        asciiTwo   <= asciiThree;
                        asciiThree <= asciiFour;
                        asciiFour  <= shiftReg;
                     end else if (shiftReg == 8'h0D || shiftReg == 8'h0A) begin
                        asciiOne   <= BLANK_CHAR;
                        asciiTwo   <= BLANK_CHAR;
                        asciiThree <= BLANK_CHAR;
                        asciiFour  <= BLANK_CHAR;
                     end else if (shiftReg == 8'h08) begin
                        asciiFour  <= asciiThree;
                        asciiThree <= asciiTwo;
                        asciiTwo   <= asciiOne;
                        asciiOne   <= BLANK_CHAR;
                     end
                  end else begin
                     frameErr <= 1'b1;
                     state    <= WAIT_IDLE;
                  end
               end else begin
                  bitCnt <= bitCnt + 16'd1;
               end
            end
            WAIT_IDLE: begin
               // A held-low line (break) must return high before any new start counts.
               if (rxS) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
